delay_line: RTL and testbench
=============================

# delay_line

Parametrised, runtime-programmable delay line for W-bit data with per-sample valid tags, clock enable (stall), synchronous flush and delay reload. It is the multi-stage generalisation of the single-cycle delay register. It sits in datapaths that must re-align one signal group against a pipeline of variable depth. With delay 1, en=1 and valid_in=1 it behaves exactly as a single D flip-flop.

## Interface
- W, 8, data bus width (≥1)
- DEPTH, 16, maximum number of delay stages (≥2)
- DEFAULT_DELAY, 1, delay loaded at reset (1..DEPTH)
- DW, $clog2(DEPTH+1), width of delay_sel / delay_cur (localparam, derived)

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- en  input  1  advance enable; 0 = stall (whole line holds)
- flush  input  1  synchronous clear of all stages
- load  input  1  latch delay_sel into delay register
- delay_sel  input  DW  requested delay in enabled cycles
- valid_in  input  1  D carries a real sample
- D  input  W  data input
- Q  output  W  delayed data (0 when valid_out=0)
- valid_out  output  1  Q carries a real sample
- delay_cur  output  DW  delay currently in effect

## Operation
- Storage: DEPTH stages stage[0..DEPTH-1], each holding W data bits and 1 valid bit.
- Shift: on a clk edge with en=1 and flush=0:
  - stage[0] ← {valid_in, valid_in ? D : 0}
  - stage[k] ← stage[k-1] for k = 1..DEPTH-1
- Stall: en=0 holds all stages. Q and valid_out hold their values, unless flush or load also clears them (see below).
- Tap: valid_out = stage[delay_cur-1].valid. Q = valid_out ? stage[delay_cur-1].data : 0. This path is combinational from registers only; there is no combinational path from D or valid_in.
- Delay register:
  - Resets to DEFAULT_DELAY.
  - On an edge with load=1, it takes clamp(delay_sel): 0 → 1, values > DEPTH → DEPTH, otherwise unchanged.
- Reload: load=1 also clears every stage valid bit and data word on the same edge, so no mixed-alignment samples reach the output.
  - Output stays invalid until delay_cur new enabled cycles have elapsed.
  - load is honoured regardless of en.
- Flush: flush=1 clears all stage data and valid bits on that edge, regardless of en. The sample present on D that cycle is discarded. delay_cur is unaffected.
- Precedence:
  - reset > flush ≈ load (both clear stages; load additionally updates delay_cur) > en shift.
  - flush=1 with load=1: stages cleared and delay updated.
- Reset (async, active-high): all stages = 0, delay_cur = DEFAULT_DELAY, Q = 0, valid_out = 0. This state holds while reset is high.

## Timing
- Latency: a sample captured at an enabled edge t appears on Q/valid_out after exactly delay_cur enabled edges (edge t counts as the first). With en held at 1 this is delay_cur clock cycles.
- Stalls stretch latency by the number of en=0 cycles; no sample is lost or duplicated.
- Throughput: one sample per enabled cycle; bubbles (valid_in=0) propagate as valid_out=0 with Q=0.
- After a flush or load at edge t, valid_out=0 until the first sample captured at an enabled edge after t has traversed delay_cur stages.
- Delay = DEPTH uses the last stage. Its contents drop off the end on the next shift; no wrap-around.
- Async reset assertion mid-stream clears the output immediately, with no clock required. Deassertion is synchronised externally; the block shifts on the first edge after deassertion if en=1.

## Test plan
- Reset/default: DEFAULT_DELAY=1, W=8, en=1, valid_in=1, D=0x11,0x22,0x33 on successive cycles → Q=0x11,0x22,0x33 each one cycle later; during reset Q=0, valid_out=0, delay_cur=1.
- Programmed delay: load delay_sel=5, then stream 0x01..0x0A with en=1 → valid_out first high exactly 5 cycles after the 0x01 capture edge; Q=0x01..0x0A in order with no gaps.
- Clamp and stall:
  - load delay_sel=0 → delay_cur=1.
  - load delay_sel=DEPTH+3 → delay_cur=DEPTH.
  - With delay 3, drop en for 4 cycles mid-stream → Q/valid_out hold; total latency is 3+4 cycles; sequence intact.
- Flush: delay 4, stream 0xA0..0xA7, assert flush with en=1 while 0xA3 is on D → valid_out=0 and Q=0 from the next cycle. 0xA3 never appears; 0xA4 appears 4 cycles after its capture.
- Reload with data in flight: delay 6 with 6 valid samples stored, then load delay_sel=2 → valid_out=0 next cycle; first new sample emerges 2 cycles after capture; no old sample is ever output.
- Bubbles and mid-stream reset: valid_in pattern 1,0,1,1,0 with D=0xFF → valid_out replicates the pattern delayed, with Q=0 on bubble slots. Asserting reset mid-stream forces Q=0, valid_out=0 and delay_cur=DEFAULT_DELAY without a clock edge.

Source files
------------

// File: rtl/delay_line.sv
// delay_line: runtime-programmable W-bit delay line with per-sample valid tags.
// A shift register of DEPTH stages is tapped at stage (delay_cur-1). Stall via
// en, synchronous clear via flush, and a reload that clears the line so samples
// captured under the old delay never reach the output.
module delay_line #(
   parameter int W             = 8,
   parameter int DEPTH         = 16,
   parameter int DEFAULT_DELAY = 1,
   localparam int DW           = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          flush,
   input  logic          load,
   input  logic [DW-1:0] delay_sel,
   input  logic          valid_in,
   input  logic [W-1:0]  D,
   output logic [W-1:0]  Q,
   output logic          valid_out,
   output logic [DW-1:0] delay_cur
);

   logic [W-1:0]     data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DW-1:0]    delay_q;
   logic [DW-1:0]    delay_d;
   logic [W-1:0]     tap_data;
   logic             tap_valid;

   // Requested delay limited to 1..DEPTH; zero would address a non-existent stage.
   always_comb begin
      delay_d = delay_sel;
      if (delay_sel == '0) begin
         delay_d = DW'(1);
      end else if (delay_sel > DW'(DEPTH)) begin
         delay_d = DW'(DEPTH);
      end
   end

   // Stage shift register and delay register; flush/load clear beats shifting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
         valid_q <= '0;
         delay_q <= DW'(DEFAULT_DELAY);
      end else begin
         if (flush || load) begin
            for (int k = 0; k < DEPTH; k++) begin
               data_q[k] <= '0;
            end
            valid_q <= '0;
         end else if (en) begin
            valid_q   <= {valid_q[DEPTH-2:0], valid_in};
            data_q[0] <= valid_in ? D : '0;
            for (int k = 1; k < DEPTH; k++) begin
               data_q[k] <= data_q[k-1];
            end
         end
         if (load) begin
            delay_q <= delay_d;
         end
      end
   end

   // Output tap: select stage delay_q-1 from registers only.
   always_comb begin
      tap_data  = '0;
      tap_valid = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (delay_q == DW'(k + 1)) begin
            tap_data  = data_q[k];
            tap_valid = valid_q[k];
         end
      end
   end

   assign valid_out = tap_valid;
   assign Q         = tap_valid ? tap_data : '0;
   assign delay_cur = delay_q;

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line: the driver pushes each expected sample with
// the enabled-edge index at which it must appear; the monitor pops on output.
module tb_delay_line;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int DW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          flush;
   logic          load;
   logic [DW-1:0] delay_sel;
   logic          valid_in;
   logic [W-1:0]  D;
   logic [W-1:0]  Q;
   logic          valid_out;
   logic [DW-1:0] delay_cur;

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   cap_cnt   = 0;
   int   edge_cnt  = 0;
   int   cur_delay = 1;

   delay_line #(.W(W), .DEPTH(DEPTH), .DEFAULT_DELAY(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .load      (load),
      .delay_sel (delay_sel),
      .valid_in  (valid_in),
      .D         (D),
      .Q         (Q),
      .valid_out (valid_out),
      .delay_cur (delay_cur)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and record the expectation.
   task automatic cyc(input logic e, input logic f, input logic l,
                      input logic [DW-1:0] s, input logic v, input logic [7:0] d);
      exp_t x;
      @(negedge clk);
      en = e; flush = f; load = l; delay_sel = s; valid_in = v; D = d;
      if (f || l) begin
         exp_q.delete();
      end else if (e) begin
         cap_cnt++;
         if (v) begin
            x.due  = cap_cnt + cur_delay - 1;
            x.data = d;
            exp_q.push_back(x);
         end
      end
   endtask

   task automatic ld(input logic [DW-1:0] s, input int new_delay);
      cyc(1'b1, 1'b0, 1'b1, s, 1'b0, 8'h00);
      cur_delay = new_delay;
      @(posedge clk);
      #1;
      chk("delay_cur_after_load", int'(delay_cur), new_delay);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 8'h00);
   endtask

   // Monitor: classify each edge from the inputs it saw, then check outputs.
   initial begin
      logic r, e, f, l, last_v;
      logic [7:0] last_q;
      exp_t x;
      last_v = 1'b0;
      last_q = '0;
      forever begin
         @(posedge clk);
         r = reset; e = en; f = flush; l = load;
         #1;
         if (r || reset) begin
            last_v = valid_out;
            last_q = Q;
            continue;
         end
         if (f || l) begin
            chk("clear_valid", int'(valid_out), 0);
            chk("clear_q", int'(Q), 0);
         end else if (e) begin
            edge_cnt++;
            if (valid_out) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_sample actual=0x%0h required=none t=%0t", Q, $time);
               end else begin
                  x = exp_q.pop_front();
                  chk("sample_data", int'(Q), int'(x.data));
                  chk("sample_edge", edge_cnt, x.due);
               end
            end else begin
               chk("bubble_q", int'(Q), 0);
               checks++;
               if (exp_q.size() != 0 && exp_q[0].due <= edge_cnt) begin
                  errors++;
                  $display("FAIL missing_sample actual=none required=0x%0h t=%0t", exp_q[0].data, $time);
               end
            end
         end else begin
            chk("stall_hold_valid", int'(valid_out), int'(last_v));
            chk("stall_hold_q", int'(Q), int'(last_q));
         end
         last_v = valid_out;
         last_q = Q;
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; flush = 1'b0; load = 1'b0;
      delay_sel = '0; valid_in = 1'b0; D = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("reset_q", int'(Q), 0);
      chk("reset_valid", int'(valid_out), 0);
      chk("reset_delay", int'(delay_cur), 1);
      @(negedge clk);
      reset = 1'b0;

      // Default delay 1 acts as a D flip-flop.
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h11);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h22);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h33);
      idle(2);

      // Programmed delay 5, gapless stream.
      ld(5'd5, 5);
      for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(i));
      idle(6);

      // Clamp at both ends, then exercise the last stage.
      ld(5'd0, 1);
      ld(5'(DEPTH + 3), DEPTH);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h5A);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h5B);
      idle(18);

      // Delay 3 with a 4-cycle stall mid-stream.
      ld(5'd3, 3);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'h30 + i));
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 8'hEE);
      for (int i = 4; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'h30 + i));
      idle(5);

      // Flush while 0xA3 is on D.
      ld(5'd4, 4);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'hA0 + i));
      cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 8'hA3);
      for (int i = 4; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'hA0 + i));
      idle(6);

      // Reload with six samples in flight.
      ld(5'd6, 6);
      for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'h60 + i));
      ld(5'd2, 2);
      for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'(8'h70 + i));
      idle(3);

      // Bubble pattern 1,0,1,1,0.
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hFF);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 8'hFF);
      idle(3);

      // Flush and load together: clear plus new delay.
      cyc(1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 8'hBB);
      cur_delay = 3;
      @(posedge clk);
      #1;
      chk("delay_cur_flush_load", int'(delay_cur), 3);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hB1);
      idle(4);
      chk("drain_empty", exp_q.size(), 0);

      // Mid-stream asynchronous reset.
      ld(5'd3, 3);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hC1);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hC2);
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'hC3);
      @(posedge clk);
      #3;
      chk("pre_reset_valid", int'(valid_out), 1);
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("async_reset_q", int'(Q), 0);
      chk("async_reset_valid", int'(valid_out), 0);
      chk("async_reset_delay", int'(delay_cur), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold_valid", int'(valid_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
